// File: rtl/serial_to_parallel_receiver.sv
// Serial-to-parallel receiver for the shift-register serial link.
// Assembles DATA_WIDTH strobed serial bits into a parallel word, MSB-first
// or LSB-first as selected when the frame starts. A completed word is
// presented on q with a one-cycle q_valid pulse; a frame restarted before
// completion is discarded and flagged with a one-cycle frame_err pulse.
module serial_to_parallel_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  sin,
  input  logic                  sin_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] sr_r;
  logic [CW-1:0]         cnt_r;
  logic                  dir_latched_r;
  logic [DATA_WIDTH-1:0] sr_next_s;

  // Next shift-register value if the current bit is accepted, per latched order.
  always_comb begin
    sr_next_s = sr_r;
    if (dir_latched_r == 1'b0) begin
      sr_next_s = {sr_r[DATA_WIDTH-2:0], sin};
    end else begin
      sr_next_s = {sin, sr_r[DATA_WIDTH-1:1]};
    end
  end

  // Frame FSM: start/restart handling, bit accumulation and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      sr_r          <= '0;
      cnt_r         <= '0;
      dir_latched_r <= 1'b0;
      q             <= '0;
      q_valid       <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          // Bits strobed while idle, even alongside start, are not taken.
          if (start) begin
            state_r       <= RECV;
            dir_latched_r <= dir;
            sr_r          <= '0;
            cnt_r         <= '0;
          end
        end
        RECV: begin
          if (start) begin
            // Restart wins over any bit strobed in the same cycle.
            frame_err     <= 1'b1;
            dir_latched_r <= dir;
            sr_r          <= '0;
            cnt_r         <= '0;
          end else if (sin_en) begin
            sr_r <= sr_next_s;
            if (cnt_r == LAST_BIT) begin
              q       <= sr_next_s;
              q_valid <= 1'b1;
              state_r <= IDLE;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          sr_r    <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign busy = (state_r == RECV);

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Self-checking bench for serial_to_parallel_receiver (DATA_WIDTH = 8).
// Expected words are queued when a frame is driven and popped when q_valid fires.
module tb_serial_to_parallel_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       sin = 1'b0;
  logic       sin_en = 1'b0;
  logic [7:0] q;
  logic       q_valid;
  logic       busy;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  logic [7:0] exp_q[$];

  serial_to_parallel_receiver #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .sin(sin),
    .sin_en(sin_en), .q(q), .q_valid(q_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (q_valid) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: q_valid with q=%h but no word expected", q);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          n_fail++;
          $display("FAIL sb_word: q=%h expected %h", q, e);
        end
      end
    end
    if (frame_err) n_ferr++;
    if (q_valid || frame_err) begin
      n_checks++;
      if (q_valid && frame_err) begin
        n_fail++;
        $display("FAIL excl: q_valid=%b frame_err=%b, expected not both", q_valid, frame_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin_en = 1'b1;
    sin    = b;
    tick();
    sin_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if (q !== 8'h00 || q_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h qv=%b busy=%b ferr=%b expected 00 0 0 0",
               q, q_valid, busy, frame_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_msb_first();
    logic [7:0] bits;
    int v0;
    bits = 8'hB2;
    v0 = n_valid;
    do_start(1'b0);
    exp_q.push_back(8'hB2);
    for (int i = 7; i >= 0; i--) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL msb_busy: busy=%b before bit %0d, expected 1", busy, 7 - i);
      end
      send_bit(bits[i]);
    end
    n_checks++;
    if (q_valid !== 1'b1 || busy !== 1'b0 || q !== 8'hB2) begin
      n_fail++;
      $display("FAIL msb_done: qv=%b busy=%b q=%h expected 1 0 b2", q_valid, busy, q);
    end
    tick();
    n_checks++;
    if (q_valid !== 1'b0 || q !== 8'hB2) begin
      n_fail++;
      $display("FAIL msb_pulse: qv=%b q=%h expected 0 b2", q_valid, q);
    end
    tick();
    n_checks++;
    if (n_valid - v0 !== 1) begin
      n_fail++;
      $display("FAIL msb_count: %0d q_valid pulses, expected 1", n_valid - v0);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits;
    int v0, f0;
    bits = 8'hB2;
    v0 = n_valid;
    f0 = n_ferr;
    do_start(1'b1);
    exp_q.push_back(8'h4D);
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    tick();
    tick();
    n_checks++;
    if (q !== 8'h4D || n_valid - v0 !== 1 || n_ferr !== f0) begin
      n_fail++;
      $display("FAIL lsb: q=%h pulses=%0d ferr=%0d expected 4d 1 0",
               q, n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bits;
    int v0;
    bits = 8'hB2;
    v0 = n_valid;
    do_start(1'b0);
    exp_q.push_back(8'hB2);
    for (int i = 7; i >= 0; i--) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        sin_en = 1'b0;
        sin    = 1'($urandom);
        tick();
      end
      send_bit(bits[i]);
    end
    tick();
    tick();
    n_checks++;
    if (q !== 8'hB2 || n_valid - v0 !== 1) begin
      n_fail++;
      $display("FAIL gaps: q=%h pulses=%0d expected b2 1", q, n_valid - v0);
    end
  endtask

  task automatic test_restart();
    logic [7:0] prev;
    int v0, f0;
    prev = q;
    v0 = n_valid;
    f0 = n_ferr;
    do_start(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    do_start(1'b0);
    n_checks++;
    if (frame_err !== 1'b1 || busy !== 1'b1 || q !== prev) begin
      n_fail++;
      $display("FAIL restart_err: ferr=%b busy=%b q=%h expected 1 1 %h",
               frame_err, busy, q, prev);
    end
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    n_checks++;
    if (q !== prev || q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_hold: q=%h qv=%b expected %h 0", q, q_valid, prev);
    end
    send_bit(1'b1);
    tick();
    tick();
    n_checks++;
    if (q !== 8'hFF || n_valid - v0 !== 1 || n_ferr - f0 !== 1) begin
      n_fail++;
      $display("FAIL restart: q=%h pulses=%0d ferr=%0d expected ff 1 1",
               q, n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] bits;
    bits = 8'hA5;
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1;
    #1;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: q=%h busy=%b qv=%b expected 00 0 0", q, busy, q_valid);
    end
    tick();
    reset = 1'b0;
    tick();
    do_start(1'b0);
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    tick();
    n_checks++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_after: q=%h expected a5", q);
    end
  endtask

  task automatic test_corners();
    logic [7:0] bits;
    logic [7:0] prev;
    int v0, f0;
    // Strobes while idle without start.
    prev = q;
    v0 = n_valid;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    tick();
    n_checks++;
    if (q !== prev || n_valid !== v0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bits: q=%h pulses=%0d busy=%b expected %h 0 0",
               q, n_valid - v0, busy, prev);
    end
    // Bit strobed together with start is not counted.
    bits = 8'h3C;
    start = 1'b1; dir = 1'b0; sin_en = 1'b1; sin = 1'b1;
    tick();
    start = 1'b0; sin_en = 1'b0;
    exp_q.push_back(8'h3C);
    for (int i = 7; i >= 1; i--) send_bit(bits[i]);
    n_checks++;
    if (q_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_bit: after 7 bits qv=%b busy=%b expected 0 1", q_valid, busy);
    end
    send_bit(bits[0]);
    n_checks++;
    if (q_valid !== 1'b1 || q !== 8'h3C) begin
      n_fail++;
      $display("FAIL start_bit_done: qv=%b q=%h expected 1 3c", q_valid, q);
    end
    // Start together with the 8th bit: restart wins.
    tick();
    v0 = n_valid;
    f0 = n_ferr;
    do_start(1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    start = 1'b1; dir = 1'b0; sin_en = 1'b1; sin = 1'b0;
    tick();
    start = 1'b0; sin_en = 1'b0;
    n_checks++;
    if (frame_err !== 1'b1 || q_valid !== 1'b0 || q !== 8'h3C) begin
      n_fail++;
      $display("FAIL start_last: ferr=%b qv=%b q=%h expected 1 0 3c", frame_err, q_valid, q);
    end
    bits = 8'h81;
    exp_q.push_back(8'h81);
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    tick();
    n_checks++;
    if (q !== 8'h81 || n_valid - v0 !== 1 || n_ferr - f0 !== 1) begin
      n_fail++;
      $display("FAIL start_last_after: q=%h pulses=%0d ferr=%0d expected 81 1 1",
               q, n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    int f0;
    f0 = n_ferr;
    bits = 8'h5A;
    do_start(1'b0);
    exp_q.push_back(8'h5A);
    for (int i = 7; i >= 1; i--) send_bit(bits[i]);
    send_bit(bits[0]);
    // q_valid is high now; start the next frame in this same cycle.
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start: ferr=%b busy=%b expected 0 1", frame_err, busy);
    end
    exp_q.push_back(8'h4D);
    bits = 8'hB2;
    for (int i = 7; i >= 0; i--) send_bit(bits[i]);
    tick();
    n_checks++;
    if (q !== 8'h4D || n_ferr !== f0) begin
      n_fail++;
      $display("FAIL b2b: q=%h ferr=%0d expected 4d 0", q, n_ferr - f0);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gaps();
    test_restart();
    test_reset_midframe();
    test_corners();
    test_back_to_back();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected words never produced, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
